vga_sync: RTL

Raster timing generator for the VGA text path: produces the pixel coordinates `x`/`y`, the `video_on` blanking flag and the `hsync`/`vsync` pulses for 640x480 at 60 Hz. It sits directly upstream of the character display stage, which consumes `x`, `y` and `video_on` to address screen RAM and the glyph renderer. `hsync`/`vsync` go straight to the VGA connector.

---
 rtl/vga_sync.sv | 110 +++++++++++
 1 files changed

// File: rtl/vga_sync.sv
// vga_sync: 640x480@60 raster timing generator.
// Produces pixel coordinates x/y, the video_on blanking flag and active-low
// hsync/vsync. All decoded outputs are registered from the next-state counter
// values so they are cycle-aligned with x/y.
// Optional feature macro: VGA_SYNC_PIX_DIV_EN
//   defined   -> clk is 50 MHz, internal divide-by-2 produces pixel_tick
//   undefined -> clk is the 25 MHz pixel clock, pixel_tick held at 1
module vga_sync #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       pixel_tick,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Counters are 10 bits wide; totals beyond 1024 cannot be represented.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
        $error("vga_sync: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       x_wrap;
    logic       y_wrap;

`ifdef VGA_SYNC_PIX_DIV_EN
    // Divide-by-2 pixel enable: first edge after reset raises it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_tick <= 1'b0;
        end else begin
            pixel_tick <= ~pixel_tick;
        end
    end
`else
    // Every clk is a pixel; enable rises on the first edge after reset and stays.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_tick <= 1'b0;
        end else begin
            pixel_tick <= 1'b1;
        end
    end
`endif

    // Next-state counter values; decode below works on these so outputs align with x/y.
    always_comb begin
        x_wrap = (x == H_LAST);
        y_wrap = (y == V_LAST);
        x_next = x;
        y_next = y;
        if (pixel_tick) begin
            if (x_wrap) begin
                x_next = '0;
                if (y_wrap) begin
                    y_next = '0;
                end else begin
                    y_next = y + 10'd1;
                end
            end else begin
                x_next = x + 10'd1;
            end
        end
    end

    // Counter and decoded-output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x           <= '0;
            y           <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            x           <= x_next;
            y           <= y_next;
            hsync       <= !((x_next >= HS_BEGIN) && (x_next <= HS_END));
            vsync       <= !((y_next >= VS_BEGIN) && (y_next <= VS_END));
            video_on    <= (x_next < H_ACT) && (y_next < V_ACT);
            frame_start <= pixel_tick && x_wrap && y_wrap;
        end
    end

endmodule
